imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_byte_packer.sv | 61 ++++++
 rtl/imem_responder.sv | 118 +++++++++++
 tb/tb_imem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - FSM state encodings (IDLE / LOAD / RUN)
//   - NOP instruction returned whenever no valid fetch is served
package imem_pkg;

  // state      | meaning
  // -----------+-----------------------------------------------
  // ST_IDLE    | after reset, nothing loaded, fetch path dead
  // ST_LOAD    | accepting program bytes from the load stream
  // ST_RUN     | program loaded, fetch path live
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst        clock, async active-low reset
//   i_clear         restart assembly at byte lane 0
//   i_accept        a byte is consumed this cycle
//   i_byte          byte value
//   i_last          byte is the final one of the stream
//   o_word          word formed by the held lanes plus i_byte, upper lanes zero
//   o_write         o_word must be committed on this edge
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_write
);

  logic [1:0] r_idx;
  logic [7:0] r_b0;
  logic [7:0] r_b1;
  logic [7:0] r_b2;

  // Lanes above the current index are never read, so zero-fill is implicit.
  always_comb begin
    o_word = 32'd0;
    case (r_idx)
      2'd0:    o_word = {24'd0, i_byte};
      2'd1:    o_word = {16'd0, i_byte, r_b0};
      2'd2:    o_word = {8'd0, i_byte, r_b1, r_b0};
      default: o_word = {i_byte, r_b2, r_b1, r_b0};
    endcase
  end

  assign o_write = i_accept && ((r_idx == 2'd3) || i_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= 2'd0;
      r_b0  <= 8'd0;
      r_b1  <= 8'd0;
      r_b2  <= 8'd0;
    end else if (i_clear) begin
      r_idx <= 2'd0;
    end else if (i_accept) begin
      if (o_write) begin
        r_idx <= 2'd0;
      end else begin
        case (r_idx)
          2'd0:    r_b0 <= i_byte;
          2'd1:    r_b1 <= i_byte;
          default: r_b2 <= i_byte;
        endcase
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with a byte-stream program loader and a
// zero-latency fetch port.
// Ports:
//   clk, rst                         clock, async active-low reset
//   imemreq_val/addr                 fetch request (byte address)
//   imemresp_data/err                fetched word / fault (misaligned or out of range)
//   load_start                       begin (re)loading a program
//   load_val/rdy/byte/last           byte stream handshake, little-endian
//   ready                            program loaded, fetch path live
//   load_err                         sticky: stream overflowed DEPTH words
//   words_loaded                     words written by current/last load
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  output logic        imemresp_err,
  input  logic        load_start,
  input  logic        load_val,
  output logic        load_rdy,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        ready,
  output logic        load_err,
  output logic [16:0] words_loaded
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [16:0] PTR_FULL = 17'(DEPTH);

  logic [1:0]  r_state;
  // Every committed write bumps the pointer, so it doubles as words_loaded
  // and saturates at DEPTH together with the write-discard.
  logic [16:0] r_ptr;
  logic        r_load_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_start;
  logic        w_accept;
  logic        w_full;
  logic        w_pk_write;
  logic        w_mem_we;
  logic [31:0] w_word;
  logic [31:0] w_off;
  logic        w_hit;

  assign w_start  = load_start && (r_state != ST_LOAD);
  assign w_accept = load_val && (r_state == ST_LOAD);
  assign w_full   = (r_ptr == PTR_FULL);
  assign w_mem_we = w_pk_write && !w_full;

  imem_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_accept (w_accept),
    .i_byte   (load_byte),
    .i_last   (load_last),
    .o_word   (w_word),
    .o_write  (w_pk_write)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 17'd0;
      r_load_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (load_start) begin
            r_state    <= ST_LOAD;
            r_ptr      <= 17'd0;
            r_load_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (w_full) r_load_err <= 1'b1;
            if (w_mem_we) r_ptr <= r_ptr + 17'd1;
            if (load_last) r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr[AW-1:0]] <= w_word;
  end

  // BASE is DEPTH*4 aligned, so one unsigned offset compare covers both bounds.
  assign w_off = imemreq_addr - BASE;
  assign w_hit = ((w_off >> (AW + 2)) == 32'd0) && (imemreq_addr[1:0] == 2'b00);

  always_comb begin
    imemresp_data = NOP;
    imemresp_err  = 1'b0;
    if ((r_state == ST_RUN) && imemreq_val) begin
      if (w_hit) imemresp_data = r_mem[w_off[AW+1:2]];
      else       imemresp_err  = 1'b1;
    end
  end

  assign load_rdy     = (r_state == ST_LOAD);
  assign ready        = (r_state == ST_RUN);
  assign load_err     = r_load_err;
  assign words_loaded = r_ptr;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: one default instance (DEPTH 256, BASE 0) and one small
// instance (DEPTH 4, BASE 0x1000) driven by the same stimulus.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        load_start;
  logic        load_val;
  logic [7:0]  load_byte;
  logic        load_last;

  logic [31:0] a_data, b_data;
  logic        a_err, b_err;
  logic        a_rdy, b_rdy;
  logic        a_ready, b_ready;
  logic        a_lerr, b_lerr;
  logic [16:0] a_wl, b_wl;

  int n_checks = 0;
  int n_errs   = 0;

  imem_responder u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .imemreq_val   (imemreq_val),
    .imemreq_addr  (imemreq_addr),
    .imemresp_data (a_data),
    .imemresp_err  (a_err),
    .load_start    (load_start),
    .load_val      (load_val),
    .load_rdy      (a_rdy),
    .load_byte     (load_byte),
    .load_last     (load_last),
    .ready         (a_ready),
    .load_err      (a_lerr),
    .words_loaded  (a_wl)
  );

  imem_responder #(.DEPTH(4), .BASE(32'h0000_1000)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .imemreq_val   (imemreq_val),
    .imemreq_addr  (imemreq_addr),
    .imemresp_data (b_data),
    .imemresp_err  (b_err),
    .load_start    (load_start),
    .load_val      (load_val),
    .load_rdy      (b_rdy),
    .load_byte     (load_byte),
    .load_last     (load_last),
    .ready         (b_ready),
    .load_err      (b_lerr),
    .words_loaded  (b_wl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_val  = 1'b1;
    load_byte = b;
    load_last = last;
    tick();
    load_val  = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    imemreq_val  = 1'b1;
    imemreq_addr = addr;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    imemreq_val = 1'b0; imemreq_addr = 32'd0;
    load_start = 1'b0; load_val = 1'b0; load_byte = 8'd0; load_last = 1'b0;
    #12;
    // reset state and IDLE fetch
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_load_rdy", {31'd0, a_rdy}, 32'd0);
    chk("rst_load_err", {31'd0, a_lerr}, 32'd0);
    chk("rst_words", {15'd0, a_wl}, 32'd0);
    fetch(32'h0);
    chk("idle_fetch_data", a_data, 32'h0000_0013);
    chk("idle_fetch_err", {31'd0, a_err}, 32'd0);
    imemreq_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // load_val high with load_start in IDLE: that byte must not be taken
    load_val = 1'b1; load_byte = 8'h13; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("start_load_rdy", {31'd0, a_rdy}, 32'd1);
    chk("start_words", {15'd0, a_wl}, 32'd0);
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b1);
    chk("p1_words", {15'd0, a_wl}, 32'd2);
    chk("p1_ready", {31'd0, a_ready}, 32'd1);
    chk("p1_load_rdy", {31'd0, a_rdy}, 32'd0);
    fetch(32'h0);
    chk("p1_fetch0", a_data, 32'h0050_0013);
    chk("p1_fetch0_err", {31'd0, a_err}, 32'd0);
    chk("b_below_base_err", {31'd0, b_err}, 32'd1);
    fetch(32'h4);
    chk("p1_fetch4", a_data, 32'h0010_0093);
    fetch(32'h2);
    chk("misalign_data", a_data, 32'h0000_0013);
    chk("misalign_err", {31'd0, a_err}, 32'd1);
    fetch(32'h400);
    chk("oor_data", a_data, 32'h0000_0013);
    chk("oor_err", {31'd0, a_err}, 32'd1);
    fetch(32'h1004);
    chk("b_base_fetch", b_data, 32'h0010_0093);
    imemreq_val = 1'b0;
    #1;
    chk("noval_data", a_data, 32'h0000_0013);
    chk("noval_err", {31'd0, a_err}, 32'd0);

    // reload from RUN with a 3-byte partial word
    pulse_start();
    chk("reload_ready", {31'd0, a_ready}, 32'd0);
    chk("reload_words", {15'd0, a_wl}, 32'd0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
    chk("p2_words", {15'd0, a_wl}, 32'd1);
    fetch(32'h0);
    chk("p2_fetch0", a_data, 32'h00CC_BBAA);
    fetch(32'h4);
    chk("p2_fetch4_kept", a_data, 32'h0010_0093);
    imemreq_val = 1'b0;

    // 20-byte stream: overflows the DEPTH=4 instance
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    chk("b_full_words", {15'd0, b_wl}, 32'd4);
    chk("b_full_no_err", {31'd0, b_lerr}, 32'd0);
    for (int i = 16; i < 20; i++) send_byte(8'(8'h10 + i), i == 19);
    chk("b_ovf_err", {31'd0, b_lerr}, 32'd1);
    chk("b_ovf_words", {15'd0, b_wl}, 32'd4);
    chk("b_ovf_ready", {31'd0, b_ready}, 32'd1);
    chk("a_20b_words", {15'd0, a_wl}, 32'd5);
    chk("a_20b_no_err", {31'd0, a_lerr}, 32'd0);
    fetch(32'h1000); chk("b_mem0", b_data, 32'h1312_1110);
    fetch(32'h1004); chk("b_mem1", b_data, 32'h1716_1514);
    fetch(32'h1008); chk("b_mem2", b_data, 32'h1B1A_1918);
    fetch(32'h100C); chk("b_mem3", b_data, 32'h1F1E_1D1C);
    fetch(32'h1010); chk("b_oor_err", {31'd0, b_err}, 32'd1);
    fetch(32'h10);   chk("a_mem4", a_data, 32'h2322_2120);
    imemreq_val = 1'b0;

    // reset after 6 accepted bytes
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, a_ready}, 32'd0);
    chk("mid_rst_load_rdy", {31'd0, a_rdy}, 32'd0);
    chk("mid_rst_words", {15'd0, a_wl}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h77, 1'b1);
    chk("post_rst_words", {15'd0, a_wl}, 32'd1);
    fetch(32'h0); chk("post_rst_mem0", a_data, 32'h0000_0077);
    fetch(32'h4); chk("post_rst_mem1_kept", a_data, 32'h1716_1514);
    fetch(32'h8); chk("post_rst_mem2_kept", a_data, 32'h1B1A_1918);
    imemreq_val = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
